// File: rtl/multicycle_alu.sv
// Multicycle ALU: one request at a time, SLL shifts one bit per cycle.
// Result, zero and illegal are registered and change only when done is raised.
module multicycle_alu (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  alucontrol,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [4:0]  shamt,
   output logic [31:0] result,
   output logic        zero,
   output logic        done,
   output logic        busy,
   output logic        illegal,
   output logic [1:0]  state_dbg
);

   // Handshake: start is taken only on an edge where state is IDLE (busy=0);
   // the request completes with a single-cycle done, and start is dropped
   // (not queued) while busy=1, including the DONE cycle.
   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, SHIFT = 2'd2, DONE = 2'd3} state_t;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SLL = 4'b0011;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_NOR = 4'b1100;

   state_t      state;
   logic [3:0]  op_q;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic [31:0] acc;
   logic [4:0]  count;
   logic [31:0] alu_out;
   logic        alu_legal;

   assign state_dbg = state;

   always_comb begin
      alu_out   = 32'd0;
      alu_legal = 1'b1;
      case (op_q)
         OP_ADD:  alu_out = a_q + b_q;
         OP_SUB:  alu_out = a_q - b_q;
         OP_AND:  alu_out = a_q & b_q;
         OP_OR:   alu_out = a_q | b_q;
         OP_NOR:  alu_out = ~(a_q | b_q);
         OP_SLT:  alu_out = ($signed(a_q) < $signed(b_q)) ? 32'd1 : 32'd0;
         OP_SLL:  alu_out = acc;  // only reached here with a zero shift count
         default: alu_legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         op_q    <= 4'd0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         acc     <= 32'd0;
         count   <= 5'd0;
         result  <= 32'd0;
         zero    <= 1'b0;
         done    <= 1'b0;
         busy    <= 1'b0;
         illegal <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  op_q  <= alucontrol;
                  a_q   <= a;
                  b_q   <= b;
                  acc   <= b;
                  count <= shamt;
                  busy  <= 1'b1;
                  state <= EXEC;
               end
            end
            EXEC: begin
               // The first shift happens here so SLL finishes in 2+shamt edges.
               if (op_q == OP_SLL && count != 5'd0) begin
                  acc   <= acc << 1;
                  count <= count - 5'd1;
                  state <= SHIFT;
               end else begin
                  result  <= alu_out;
                  zero    <= (alu_out == 32'd0);
                  illegal <= ~alu_legal;
                  done    <= 1'b1;
                  state   <= DONE;
               end
            end
            SHIFT: begin
               if (count != 5'd0) begin
                  acc   <= acc << 1;
                  count <= count - 5'd1;
               end else begin
                  result  <= acc;
                  zero    <= (acc == 32'd0);
                  illegal <= 1'b0;
                  done    <= 1'b1;
                  state   <= DONE;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
